vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
- Receiving end of the VGA link: samples hSync/vSync/rgb as driven by the display controller and bitchange logic, and recovers pixel position.
- Checks line and frame timing against 640x480@60 parameters and declares lock.
- Captures the rgb value at one programmable probe pixel, so the on-board picture can be checked or shown on the SSD.
- Sits beside display_controller in the top level, on the same 100 MHz clock.

Parameters:
CLK_DIV, 4, system clocks per pixel
H_TOTAL, 800, pixels per line
V_TOTAL, 525, lines per frame
H_ACT_START, 144, first active pixel after hSync falling edge
V_ACT_START, 35, first active line after vSync falling edge
LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  synchronous reset, active-low
hSync  input  1  horizontal sync, active-low
vSync  input  1  vertical sync, active-low
rgb  input  12  pixel colour {R,G,B}
probe_x  input  10  active-relative probe column (0..639)
probe_y  input  10  active-relative probe row (0..479)
locked  output  1  timing lock
h_pos  output  10  recovered pixel index since hSync fall
v_pos  output  10  recovered line index since vSync fall
active  output  1  h_pos/v_pos inside 640x480 active window
probe_rgb  output  12  last captured probe colour
probe_valid  output  1  one-cycle pulse on probe capture
err_count  output  8  timing errors since reset, saturating at 255

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, FSM=SEARCH, all counters 0, input registers loaded with 1 (idle sync level).
- Input stage: hSync/vSync/rgb are registered once. Edges are detected on registered vs previous-registered values. All internal decisions lag the pins by 2 clk.
- Pixel timing:
  - clk_cnt counts 0..CLK_DIV-1.
  - h_pos increments when clk_cnt==CLK_DIV-1 and saturates at 1023.
  - hSync fall: h_pos<=0, clk_cnt<=0.
- Line check on hSync fall: the line is good iff h_pos==H_TOTAL-1 and clk_cnt==CLK_DIV-1 (exactly H_TOTAL*CLK_DIV clks). The first hSync fall after reset or after leaving SEARCH is not checked.
- Lines:
  - hSync fall alone: v_pos<=v_pos+1, saturating at 1023.
  - vSync fall: v_pos<=0.
  - Simultaneous hSync and vSync fall: v_pos<=0; the line check still applies.
- Frame check on vSync fall: the frame is good iff v_pos==V_TOTAL-1 before clearing and every line in the frame was good.
- FSM:
  - SEARCH: wait for vSync fall, then go to ACQUIRE with good_frames=0.
  - ACQUIRE:
    - Good frame: good_frames+1. When it reaches LOCK_FRAMES, go to LOCKED and set locked=1 in the same cycle as the transition.
    - Bad line or bad frame: good_frames<=0, stay in ACQUIRE, err_count unchanged.
  - LOCKED:
    - Bad line or bad frame: err_count+1 (saturating), locked<=0, go to ACQUIRE.
    - h_pos reaching 1023 (sync loss): locked<=0, err_count+1, go to SEARCH.
  - In any state, h_pos reaching 1023 sends the FSM to SEARCH. err_count increments only if leaving LOCKED.
  - Two errors in the same cycle count once.
- active = locked and H_ACT_START<=h_pos<H_ACT_START+640 and V_ACT_START<=v_pos<V_ACT_START+480. Registered together with h_pos/v_pos.
- Probe capture:
  - Condition: locked, h_pos==H_ACT_START+probe_x, v_pos==V_ACT_START+probe_y, and clk_cnt==CLK_DIV/2 (mid-pixel sample).
  - On capture, probe_rgb<=registered rgb and probe_valid=1 for exactly one clk.
  - Out-of-range probe coordinates never capture. probe_rgb holds between captures.
  - probe_x/probe_y are sampled live; a change takes effect on the next matching pixel.
- Width rules: comparisons use 11-bit sums to avoid wrap. All counters are unsigned.
- Reset mid-frame: immediate return to SEARCH with lock lost. err_count is cleared only by reset.

Decomposition:
- Shared package vga_timing_pkg holds H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START, H_ACTIVE=640, V_ACTIVE=480, CLK_DIV, and the FSM state encoding (SEARCH=2'd0, ACQUIRE=2'd1, LOCKED=2'd2). display_controller reuses the same timing constants.
- One sub-module, sync_edge_detect: input register plus fall-edge pulse, instantiated for hSync and vSync.

Test Plan:
- Drive display_controller-timed syncs (800x525, CLK_DIV=4) after reset -> locked=0 through the first partial frame; locked rises at the 2nd good vSync fall after SEARCH exits; err_count=0.
- Locked; drive one line of 799 pixels (3196 clks) -> locked falls 2 clk after that hSync edge; err_count=1; relock after 2 more good frames.
- Locked; hold hSync high for 1100 pixel times -> FSM reaches SEARCH when h_pos=1023; err_count+1; h_pos stays at 1023.
- probe=(0,0), rgb=12'hF00 only at the first active pixel, else 12'h000 -> probe_valid pulses once per frame; probe_rgb=12'hF00.
- probe=(639,479) with a colour ramp -> captured value equals the driven value at the last active pixel; probe=(640,0) -> probe_valid never asserts.
- Assert rst_n=0 mid-frame while locked with err_count=5 -> next edge shows locked=0, err_count=0, probe_rgb=0, h_pos=v_pos=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and receiver state encoding.
// display_controller draws on the same constants.
package vga_timing_pkg;
    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int H_ACT_START = 144;
    localparam int V_ACT_START = 35;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int LOCK_FRAMES = 2;

    localparam logic [9:0] POS_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } syncState_t;

    // 11-bit compare so that start+len never wraps the 10-bit position range
    function automatic logic inWindow(input logic [9:0] pos, input int start, input int len);
        return ({1'b0, pos} >= 11'(start)) && ({1'b0, pos} < 11'(start + len));
    endfunction
endpackage

// File: rtl/vga_sync_receiver_if.sv
// VGA link as seen by the receiver: sync/pixel inputs, probe setup, and recovered timing.
interface vga_sync_receiver_if;
    logic        hSync;
    logic        vSync;
    logic [11:0] rgb;
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic        locked;
    logic [9:0]  h_pos;
    logic [9:0]  v_pos;
    logic        active;
    logic [11:0] probe_rgb;
    logic        probe_valid;
    logic [7:0]  err_count;

    modport master (
        output hSync, vSync, rgb, probe_x, probe_y,
        input  locked, h_pos, v_pos, active, probe_rgb, probe_valid, err_count
    );
    modport slave (
        input  hSync, vSync, rgb, probe_x, probe_y,
        output locked, h_pos, v_pos, active, probe_rgb, probe_valid, err_count
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync input and flags its falling edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);
    logic q, qPrev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= 1'b1;
            qPrev <= 1'b1;
        end else begin
            q     <= din;
            qPrev <= q;
        end
    end

    assign fall = qPrev & ~q;
endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receiver: recovers pixel position from hSync/vSync, qualifies timing into a lock,
// and samples the colour of one programmable probe pixel.
module vga_sync_receiver #(
    parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
    parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input logic               clk,
    input logic               rst_n,
    vga_sync_receiver_if.slave bus
);
    import vga_timing_pkg::*;

    localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GF_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CLK_MID  = CW'(CLK_DIV / 2);

    logic [1:0]      syncIn, syncFall;
    logic            hFall, vFall;
    logic [11:0]     rgbQ;
    logic [CW-1:0]   clkCnt, clkNxt;
    logic [9:0]      hPos, vPos, hNxt, vNxt;
    logic            activeWin;
    syncState_t      state;
    logic [GF_W-1:0] goodFrames;
    logic            locked, lineArmed, frameOk;
    logic [7:0]      errCount;
    logic [11:0]     probeRgb;
    logic            probeValid;

    assign syncIn = {bus.hSync, bus.vSync};
    for (genvar i = 0; i < 2; i++) begin : gSync
        sync_edge_detect uEdge (.clk(clk), .rst_n(rst_n), .din(syncIn[i]), .fall(syncFall[i]));
    end
    assign hFall = syncFall[1];
    assign vFall = syncFall[0];

    logic pixEnd, lineGood, checking, lineBad, frameBad, frameGood, syncLoss;
    assign pixEnd    = (clkCnt == CLK_LAST);
    assign lineGood  = (hPos == 10'(H_TOTAL - 1)) && pixEnd;
    assign checking  = (state != SEARCH);
    assign lineBad   = hFall && lineArmed && checking && !lineGood;
    assign frameBad  = vFall && checking && ((vPos != 10'(V_TOTAL - 1)) || !frameOk || lineBad);
    assign frameGood = vFall && checking && !frameBad;
    // A fresh hSync fall clears h_pos this cycle, so a saturated count is not a loss then
    assign syncLoss  = (hPos == POS_MAX) && !hFall;

    always_comb begin
        clkNxt = pixEnd ? '0 : clkCnt + 1'b1;
        hNxt   = (pixEnd && hPos != POS_MAX) ? hPos + 10'd1 : hPos;
        vNxt   = vPos;
        if (hFall) begin
            clkNxt = '0;
            hNxt   = '0;
            if (vPos != POS_MAX) vNxt = vPos + 10'd1;
        end
        if (vFall) vNxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgbQ      <= '0;
            clkCnt    <= '0;
            hPos      <= '0;
            vPos      <= '0;
            activeWin <= 1'b0;
            lineArmed <= 1'b0;
            frameOk   <= 1'b0;
        end else begin
            rgbQ      <= bus.rgb;
            clkCnt    <= clkNxt;
            hPos      <= hNxt;
            vPos      <= vNxt;
            activeWin <= inWindow(hNxt, H_ACT_START, H_ACTIVE) && inWindow(vNxt, V_ACT_START, V_ACTIVE);
            // The first line seen after leaving SEARCH has an unknown start, so skip its check
            if (state == SEARCH || syncLoss) lineArmed <= 1'b0;
            else if (hFall)                  lineArmed <= 1'b1;
            if (vFall)        frameOk <= 1'b1;
            else if (lineBad) frameOk <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SEARCH;
            goodFrames <= '0;
            locked     <= 1'b0;
            errCount   <= '0;
        end else begin
            case (state)
                SEARCH: if (vFall && !syncLoss) begin
                    state      <= ACQUIRE;
                    goodFrames <= '0;
                end
                ACQUIRE: begin
                    if (syncLoss) state <= SEARCH;
                    else if (lineBad || frameBad) goodFrames <= '0;
                    else if (frameGood) begin
                        goodFrames <= goodFrames + 1'b1;
                        if (goodFrames == GF_W'(LOCK_FRAMES - 1)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: if (syncLoss || lineBad || frameBad) begin
                    state      <= syncLoss ? SEARCH : ACQUIRE;
                    locked     <= 1'b0;
                    goodFrames <= '0;
                    if (errCount != 8'hFF) errCount <= errCount + 8'd1;
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    logic [10:0] probeH, probeV;
    logic        probeHit;
    assign probeH   = 11'(H_ACT_START) + {1'b0, bus.probe_x};
    assign probeV   = 11'(V_ACT_START) + {1'b0, bus.probe_y};
    assign probeHit = locked && ({1'b0, bus.probe_x} < 11'(H_ACTIVE)) && ({1'b0, bus.probe_y} < 11'(V_ACTIVE))
                   && ({1'b0, hPos} == probeH) && ({1'b0, vPos} == probeV) && (clkCnt == CLK_MID);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            probeRgb   <= '0;
            probeValid <= 1'b0;
        end else begin
            probeValid <= probeHit;
            if (probeHit) probeRgb <= rgbQ;
        end
    end

    assign bus.locked      = locked;
    assign bus.h_pos       = hPos;
    assign bus.v_pos       = vPos;
    assign bus.active      = locked & activeWin;
    assign bus.probe_rgb   = probeRgb;
    assign bus.probe_valid = probeValid;
    assign bus.err_count   = errCount;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster; probe captures are scoreboarded.
module tb_vga_sync_receiver;
    localparam int CD = 4, HT = 32, VT = 10, HAS = 6, VAS = 3, HA = 22, VA = 6, HSW = 3, VSW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    vga_sync_receiver_if bus();

    vga_sync_receiver #(
        .CLK_DIV(CD), .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .V_ACT_START(VAS),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int capCount = 0, colourMode = 0, probeX = HA, probeY = 0, expErr = 0;
    logic [11:0] sbq[$];

    function automatic logic [11:0] colourAt(input int ln, input int px);
        if (colourMode == 1) return (ln == VAS && px == HAS) ? 12'hF00 : 12'h000;
        return 12'(ln * 64 + px * 3 + 1);
    endfunction

    task automatic setProbe(input int x, input int y);
        probeX = x; probeY = y;
        bus.probe_x = 10'(x);
        bus.probe_y = 10'(y);
    endtask

    // Drives clocks k0..k1-1 of a line; any probe capture seen is matched against the scoreboard
    task automatic drive_span(input int ln, input int k0, input int k1);
        int px;
        logic [11:0] expRgb;
        for (int k = k0; k < k1; k++) begin
            @(negedge clk);
            if (bus.probe_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL probe_unexpected got=%h expected no capture", bus.probe_rgb);
                end else begin
                    expRgb = sbq.pop_front();
                    capCount++;
                    if (bus.probe_rgb !== expRgb) begin
                        failures++;
                        $display("FAIL probe_rgb got=%h exp=%h", bus.probe_rgb, expRgb);
                    end
                end
            end
            px = k / CD;
            bus.hSync = (px < HSW) ? 1'b0 : 1'b1;
            bus.vSync = (ln < VSW) ? 1'b0 : 1'b1;
            bus.rgb   = colourAt(ln, px);
            if (k % CD == 0 && probeX < HA && probeY < VA && px == HAS + probeX && ln == VAS + probeY)
                sbq.push_back(colourAt(ln, px));
        end
    endtask

    task automatic drive_line(input int ln, input int npx);
        drive_span(ln, 0, npx * CD);
    endtask

    task automatic drive_lines(input int a, input int b);
        for (int ln = a; ln <= b; ln++) drive_line(ln, HT);
    endtask

    task automatic drive_frame();
        drive_lines(0, VT - 1);
    endtask

    // Two good frames to requalify, a third during which lock is held
    task automatic relock();
        drive_frame();
        drive_frame();
        drive_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.hSync = 1'b1; bus.vSync = 1'b1; bus.rgb = 12'h0;
        setProbe(HA, 0);
        repeat (3) @(negedge clk);
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
        checks++; if (bus.h_pos !== 10'd0 || bus.v_pos !== 10'd0) begin failures++; $display("FAIL reset_pos got=%0d/%0d exp=0/0", bus.h_pos, bus.v_pos); end
        checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", bus.err_count); end
        checks++; if (bus.probe_rgb !== 12'h0 || bus.probe_valid !== 1'b0) begin failures++; $display("FAIL reset_probe got=%h/%b exp=0/0", bus.probe_rgb, bus.probe_valid); end
        checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", bus.active); end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        drive_lines(6, VT - 1);
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL lock_partial got=%b exp=0", bus.locked); end
        drive_frame();
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL lock_frame1 got=%b exp=0", bus.locked); end
        drive_frame();
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL lock_frame2 got=%b exp=0", bus.locked); end
        drive_line(0, HT);
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL lock_rise got=%b exp=1", bus.locked); end
        checks++; if (bus.err_count !== 8'(expErr)) begin failures++; $display("FAIL lock_err got=%0d exp=%0d", bus.err_count, expErr); end
        drive_lines(1, VT - 1);
    endtask

    task automatic test_badline();
        drive_lines(0, 4);
        drive_line(5, HT - 1);
        drive_span(6, 0, 1);
        drive_span(6, 1, 2);
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL badline_early got=%b exp=1", bus.locked); end
        drive_span(6, 2, 3);
        expErr++;
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL badline_drop got=%b exp=0", bus.locked); end
        checks++; if (bus.err_count !== 8'(expErr)) begin failures++; $display("FAIL badline_err got=%0d exp=%0d", bus.err_count, expErr); end
        drive_span(6, 3, HT * CD);
        drive_lines(7, VT - 1);
        relock();
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL badline_relock got=%b exp=1", bus.locked); end
    endtask

    task automatic test_syncloss();
        for (int k = 0; k < 1100 * CD; k++) begin
            @(negedge clk);
            bus.hSync = 1'b1; bus.vSync = 1'b1; bus.rgb = 12'h0;
        end
        expErr++;
        checks++; if (bus.h_pos !== 10'd1023) begin failures++; $display("FAIL syncloss_hpos got=%0d exp=1023", bus.h_pos); end
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL syncloss_locked got=%b exp=0", bus.locked); end
        checks++; if (bus.err_count !== 8'(expErr)) begin failures++; $display("FAIL syncloss_err got=%0d exp=%0d", bus.err_count, expErr); end
        drive_frame();
        relock();
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL syncloss_relock got=%b exp=1", bus.locked); end
    endtask

    task automatic test_probe_first();
        colourMode = 1;
        setProbe(0, 0);
        capCount = 0;
        drive_lines(0, 4);
        drive_span(5, 0, 80);
        checks++; if (bus.active !== 1'b1) begin failures++; $display("FAIL active_inside got=%b exp=1", bus.active); end
        drive_span(5, 80, 120);
        checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL active_blank got=%b exp=0", bus.active); end
        drive_span(5, 120, HT * CD);
        drive_lines(6, VT - 1);
        drive_frame();
        checks++; if (capCount !== 2 || sbq.size() != 0) begin failures++; $display("FAIL probe_first_count got=%0d pending=%0d exp=2/0", capCount, sbq.size()); end
        checks++; if (bus.probe_rgb !== 12'hF00) begin failures++; $display("FAIL probe_first_hold got=%h exp=f00", bus.probe_rgb); end
    endtask

    task automatic test_probe_last();
        colourMode = 0;
        setProbe(HA - 1, VA - 1);
        capCount = 0;
        drive_frame();
        checks++; if (capCount !== 1 || sbq.size() != 0) begin failures++; $display("FAIL probe_last_count got=%0d exp=1", capCount); end
        checks++; if (bus.probe_rgb !== colourAt(VAS + VA - 1, HAS + HA - 1)) begin failures++; $display("FAIL probe_last_rgb got=%h exp=%h", bus.probe_rgb, colourAt(VAS + VA - 1, HAS + HA - 1)); end
    endtask

    task automatic test_probe_oor();
        setProbe(HA, 0);
        capCount = 0;
        drive_frame();
        checks++; if (capCount !== 0) begin failures++; $display("FAIL probe_oor_count got=%0d exp=0", capCount); end
        checks++; if (bus.probe_rgb !== colourAt(VAS + VA - 1, HAS + HA - 1)) begin failures++; $display("FAIL probe_oor_hold got=%h exp=%h", bus.probe_rgb, colourAt(VAS + VA - 1, HAS + HA - 1)); end
    endtask

    task automatic test_err_accum();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive_lines(0, VT - 2);
            else begin
                drive_lines(0, 4);
                drive_line(5, HT - 1);
                drive_lines(6, VT - 1);
            end
            expErr++;
            relock();
            checks++; if (bus.err_count !== 8'(expErr)) begin failures++; $display("FAIL accum_err%0d got=%0d exp=%0d", i, bus.err_count, expErr); end
            checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL accum_relock%0d got=%b exp=1", i, bus.locked); end
        end
    endtask

    task automatic test_reset_midframe();
        drive_lines(0, 4);
        drive_span(5, 0, 40);
        checks++; if (bus.err_count !== 8'd5 || bus.locked !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0d/%b exp=5/1", bus.err_count, bus.locked); end
        rst_n = 1'b0;
        drive_span(5, 40, 41);
        checks++; if (bus.locked !== 1'b0 || bus.err_count !== 8'd0) begin failures++; $display("FAIL midreset_lock got=%b/%0d exp=0/0", bus.locked, bus.err_count); end
        checks++; if (bus.probe_rgb !== 12'h0) begin failures++; $display("FAIL midreset_probe got=%h exp=0", bus.probe_rgb); end
        checks++; if (bus.h_pos !== 10'd0 || bus.v_pos !== 10'd0) begin failures++; $display("FAIL midreset_pos got=%0d/%0d exp=0/0", bus.h_pos, bus.v_pos); end
        rst_n = 1'b1;
        drive_span(5, 41, 44);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_badline();
        test_syncloss();
        test_probe_first();
        test_probe_last();
        test_probe_oor();
        test_err_accum();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
